// File: rtl/svm_seq_engine_pkg.sv
// Shared types and sizing helpers for the sequential one-vs-one SVM engine.
package svm_engine_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        RESULT = 2'd2
    } svm_state_e;

    // Accumulator must hold bias plus N products of a signed weight and an unsigned feature.
    function automatic int acc_width(input int n_feat, input int w_w, input int in_w, input int b_w);
        int prod_sum_w;
        prod_sum_w = w_w + in_w + 1 + $clog2(n_feat);
        return ((prod_sum_w > b_w) ? prod_sum_w : b_w) + 1;
    endfunction

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/svm_seq_engine_if.sv
// Picker-to-engine bundle: feature/weight/bias inputs, run control and per-comparison result.
interface svm_seq_engine_if #(
    parameter int N_features  = 11,
    parameter int weightWidth = 8,
    parameter int biasWidth   = 16,
    parameter int inputWidth  = 4
);
    logic                              start;
    logic [inputWidth*N_features-1:0]  features;
    logic [weightWidth*N_features-1:0] weight;
    logic [biasWidth-1:0]              bia;
    logic                              done;
    logic                              svmready;
    logic                              w_class;
    logic                              busy;

    modport master (
        output start, features, weight, bia, done,
        input  svmready, w_class, busy
    );

    modport slave (
        input  start, features, weight, bia, done,
        output svmready, w_class, busy
    );
endinterface

// File: rtl/svm_seq_engine_mac_step.sv
// One multiply-accumulate step: signed weight times zero-extended feature, added to the running sum.
module svm_mac_step #(
    parameter int weightWidth = 8,
    parameter int inputWidth  = 4,
    parameter int ACC_W       = 18
) (
    input  logic signed [weightWidth-1:0] w_i,
    input  logic        [inputWidth-1:0]  x_i,
    input  logic signed [ACC_W-1:0]       addend_i,
    output logic signed [ACC_W-1:0]       sum_o
);
    localparam int PW = weightWidth + inputWidth + 1;

    logic signed [inputWidth:0] x_ext;
    logic signed [PW-1:0]       prod;

    always_comb begin
        x_ext = $signed({1'b0, x_i});
        prod  = PW'(w_i) * PW'(x_ext);
        sum_o = addend_i + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
endmodule

// File: rtl/svm_seq_engine.sv
// Sequential SVM engine: one MAC per cycle over the latched features, one result pulse per comparison.
module svm_seq_engine
    import svm_engine_pkg::*;
#(
    parameter int N_features  = 11,
    parameter int weightWidth = 8,
    parameter int biasWidth   = 16,
    parameter int inputWidth  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    svm_seq_engine_if.slave   bus
);
    localparam int ACC_W = acc_width(N_features, weightWidth, inputWidth, biasWidth);
    localparam int IDX_W = (N_features > 1) ? $clog2(N_features) : 1;
    localparam int FW    = inputWidth * N_features;

    svm_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [FW-1:0]           feat_q, feat_d;
    logic                    svmready_q, svmready_d;
    logic                    w_class_q, w_class_d;

    logic signed [weightWidth-1:0] w_arr [N_features];
    logic        [inputWidth-1:0]  x_arr [N_features];
    logic signed [ACC_W-1:0]       addend;
    logic signed [ACC_W-1:0]       mac_sum;
    logic                          idx_first;
    logic                          idx_last;

    genvar gi;
    generate
        for (gi = 0; gi < N_features; gi++) begin : g_slice
            assign w_arr[gi] = bus.weight[slice_lsb(gi, weightWidth) +: weightWidth];
            assign x_arr[gi] = feat_q[slice_lsb(gi, inputWidth) +: inputWidth];
        end
    endgenerate

    assign idx_first = (idx_q == '0);
    assign idx_last  = (idx_q == IDX_W'(N_features - 1));
    // The bias seeds the sum only on the first index; later steps chain off the accumulator.
    assign addend    = idx_first ? {{(ACC_W-biasWidth){bus.bia[biasWidth-1]}}, bus.bia} : acc_q;

    svm_mac_step #(
        .weightWidth (weightWidth),
        .inputWidth  (inputWidth),
        .ACC_W       (ACC_W)
    ) u_mac (
        .w_i      (w_arr[idx_q]),
        .x_i      (x_arr[idx_q]),
        .addend_i (addend),
        .sum_o    (mac_sum)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        feat_d     = feat_q;
        svmready_d = 1'b0;
        w_class_d  = w_class_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    feat_d  = bus.features;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (idx_first && bus.done) begin
                    state_d = IDLE;
                end else begin
                    acc_d = mac_sum;
                    if (idx_last) begin
                        // Decision registered with the pulse so both are valid during RESULT.
                        idx_d      = '0;
                        state_d    = RESULT;
                        svmready_d = 1'b1;
                        w_class_d  = mac_sum[ACC_W-1];
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RESULT: begin
                idx_d   = '0;
                state_d = ACC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            feat_q     <= '0;
            svmready_q <= 1'b0;
            w_class_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            feat_q     <= feat_d;
            svmready_q <= svmready_d;
            w_class_q  <= w_class_d;
        end
    end

    assign bus.svmready = svmready_q;
    assign bus.w_class  = w_class_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_svm_seq_engine.sv
// Self-checking bench: directed and randomized comparisons against an arithmetic reference model.
module tb_svm_seq_engine;
    localparam int NF = 2;
    localparam int WW = 4;
    localparam int BW = 8;
    localparam int IW = 4;
    localparam int LAT = NF + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    int fx [NF];
    int cw [8][NF];
    int cb [8];
    int obs [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    svm_seq_engine_if #(.N_features(NF), .weightWidth(WW), .biasWidth(BW), .inputWidth(IW)) bus ();

    svm_seq_engine #(.N_features(NF), .weightWidth(WW), .biasWidth(BW), .inputWidth(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int model_sum(input int k);
        int s;
        s = cb[k];
        for (int i = 0; i < NF; i++) s += cw[k][i] * fx[i];
        return s;
    endfunction

    task automatic load_cmp(input int k);
        for (int i = 0; i < NF; i++) bus.weight[i*WW +: WW] = WW'(cw[k][i]);
        bus.bia = BW'(cb[k]);
    endtask

    task automatic load_features();
        for (int i = 0; i < NF; i++) bus.features[i*IW +: IW] = IW'(fx[i]);
    endtask

    // Runs nc comparisons, with done raised the cycle after the last pulse, as the picker does.
    task automatic run_seq(input int nc, input bit mid_start, input string tag);
        int n;
        int s;
        int start_cyc;
        load_features();
        load_cmp(0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_rise: got %b want 1", tag, bus.busy);
        end
        for (int k = 0; k < nc; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (mid_start && k == 0 && n == 1) begin
                    bus.start = 1'b1;
                    for (int i = 0; i < NF; i++) bus.features[i*IW +: IW] = IW'(15 - fx[i]);
                end else if (mid_start && k == 0 && n == 2) begin
                    bus.start = 1'b0;
                    load_features();
                end
                if (mid_start) begin
                    tests++;
                    if (bus.busy !== 1'b1) begin
                        fails++;
                        $display("FAIL %s busy_hold cmp%0d: got %b want 1", tag, k, bus.busy);
                    end
                end
            end while (bus.svmready !== 1'b1 && n < 10);
            tests++;
            if (n != LAT) begin
                fails++;
                $display("FAIL %s latency cmp%0d: got %0d cycles want %0d", tag, k, n, LAT);
            end
            s = model_sum(k);
            tests++;
            if (bus.w_class !== (s < 0)) begin
                fails++;
                $display("FAIL %s w_class cmp%0d: got %b want %b (sum %0d)", tag, k, bus.w_class, (s < 0), s);
            end
            obs[k] = int'(bus.w_class);
            $display("[TB] %s cmp%0d sum=%0d w_class=%b latency=%0d", tag, k, s, bus.w_class, n);
            @(posedge clk);
            #1;
            if (k < nc - 1) load_cmp(k + 1);
            else bus.done = 1'b1;
        end
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b1 || bus.svmready !== 1'b0) begin
            fails++;
            $display("FAIL %s done_cycle: got busy=%b svmready=%b want 1/0", tag, bus.busy, bus.svmready);
        end
        @(posedge clk);
        #1;
        bus.done = 1'b0;
        tests++;
        if (bus.busy !== 1'b0 || (cyc - start_cyc) != nc * LAT + 1) begin
            fails++;
            $display("FAIL %s idle_time: got busy=%b after %0d cycles want 0 after %0d",
                     tag, bus.busy, cyc - start_cyc, nc * LAT + 1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (bus.svmready !== 1'b0 || bus.w_class !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got svmready=%b w_class=%b busy=%b want 0/0/0",
                     bus.svmready, bus.w_class, bus.busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("[TB] reset released");
    endtask

    task automatic test_directed();
        int bias_tab [3] = '{0, -2, -1};
        fx[0] = 3; fx[1] = 5;
        for (int t = 0; t < 3; t++) begin
            cw[0][0] = 2; cw[0][1] = -1; cb[0] = bias_tab[t];
            run_seq(1, 1'b0, "directed");
        end
    endtask

    task automatic test_extremes();
        fx[0] = 15; fx[1] = 15;
        cw[0][0] = -8; cw[0][1] = -8; cb[0] = -128;
        tests++;
        if (model_sum(0) != -368) begin
            fails++;
            $display("FAIL extremes_model: got %0d want -368", model_sum(0));
        end
        run_seq(1, 1'b0, "extremes");
    endtask

    task automatic test_seven_class();
        int winner;
        fx[0] = int'($urandom_range(15)); fx[1] = int'($urandom_range(15));
        for (int k = 0; k < 6; k++) begin
            cw[k][0] = 0; cw[k][1] = 0;
            cb[k] = (k < 4) ? -1 : 1;
        end
        run_seq(6, 1'b0, "seven_class");
        winner = 0;
        for (int k = 0; k < 6; k++) if (obs[k] == 1) winner = k + 1;
        tests++;
        if (winner != 4) begin
            fails++;
            $display("FAIL seven_class winner: got %0d want 4", winner);
        end
    endtask

    task automatic test_random(input int runs, input bit mid_start);
        for (int r = 0; r < runs; r++) begin
            for (int i = 0; i < NF; i++) fx[i] = int'($urandom_range(15));
            for (int k = 0; k < 6; k++) begin
                for (int i = 0; i < NF; i++) cw[k][i] = int'($urandom_range(15)) - 8;
                cb[k] = int'($urandom_range(255)) - 128;
            end
            run_seq(6, mid_start, mid_start ? "mid_start" : "random");
        end
    endtask

    task automatic test_reset_mid_run();
        fx[0] = 15; fx[1] = 15;
        cw[0][0] = -8; cw[0][1] = -8; cb[0] = -128;
        run_seq(1, 1'b0, "pre_reset");
        load_cmp(0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.svmready !== 1'b0 || bus.busy !== 1'b0 || bus.w_class !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_run: got svmready=%b busy=%b w_class=%b want 0/0/0",
                     bus.svmready, bus.busy, bus.w_class);
        end
        repeat (4) begin
            @(negedge clk);
            tests++;
            if (bus.svmready !== 1'b0) begin
                fails++;
                $display("FAIL reset_no_pulse: got svmready=%b want 0", bus.svmready);
            end
        end
        $display("[TB] reset during ACC idx=1 discarded comparison");
        fx[0] = 3; fx[1] = 5;
        cw[0][0] = 2; cw[0][1] = -1; cb[0] = -2;
        run_seq(1, 1'b0, "post_reset");
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.done     = 1'b0;
        bus.features = '0;
        bus.weight   = '0;
        bus.bia      = '0;
        test_reset();
        test_directed();
        test_extremes();
        test_seven_class();
        test_random(4, 1'b0);
        test_random(1, 1'b1);
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/svm_seq_engine.md
# svm_seq_engine

Sequential one-vs-one SVM evaluation engine; the compute responder for the `SVM_PICKER_7_CLASS` scheduler. It latches one feature vector and evaluates one binary SVM per comparison against the weights and bias the picker presents, using one multiply-accumulate per cycle. Each comparison ends with a one-cycle `svmready` pulse and the `w_class` decision. The engine repeats comparisons until the picker signals completion.

## Interface
- `N_features`, 11: features per sample.
- `weightWidth`, 8: signed weight width.
- `biasWidth`, 16: signed bias width.
- `inputWidth`, 4: unsigned feature width.
- `ACC_W`, derived: max(weightWidth+inputWidth+1+clog2(N_features), biasWidth) + 1; signed accumulator width.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to latch `features` and begin; honoured only in IDLE.
- `features`  in  inputWidth*N_features  unsigned feature vector; feature i at bits [i*inputWidth +: inputWidth].
- `weight`  in  weightWidth*N_features  signed weights from picker; weight i at the same slicing as feature i.
- `bia`  in  biasWidth  signed bias from picker.
- `done`  in  1  picker `ready`; ends the run.
- `svmready`  out  1  registered; one-cycle pulse when a comparison result is valid.
- `w_class`  out  1  registered decision; held between pulses.
- `busy`  out  1  high outside IDLE.

## Operation
- The state machine has three states: IDLE, ACC, RESULT.
- **IDLE:** when `start`=1, latch `features`, set idx←0, and go to ACC. Otherwise stay in IDLE.
- **ACC, idx=0:**
  - If `done`=1, go to IDLE. acc and w_class are not updated.
  - Otherwise acc ← sext(`bia`) + w[0]·x[0].
- **ACC, idx>0:** acc ← acc + w[idx]·x[idx].
- **ACC, all indices:** idx increments each cycle. After idx=N_features−1, go to RESULT.
- **RESULT:**
  - Assert `svmready` and set w_class ← 1 if the final sum is strictly negative, else 0. Here w_class=0 means the lower class index wins and w_class=1 means the higher index wins.
  - Go to ACC with idx←0 to start the next comparison.
- **Arithmetic:** each product is a signed weight times a zero-extended feature, sign-extended to ACC_W. No saturation is needed; ACC_W is sized so overflow cannot occur.
- **Weight stability:** the picker changes weights only on the edge where `svmready`=1. `weight` and `bia` are therefore stable for every ACC cycle of a comparison. The engine reads `bia` only in the idx=0 cycle.
- **Boundary conditions:**
  - `start` while busy is ignored and the latched features are unchanged.
  - `done`=1 in any state other than ACC idx=0 is ignored.
  - `rst_n`=0 at any cycle gives state=IDLE, idx=0, acc=0, `svmready`=0, `w_class`=0, `busy`=0 on the next edge. A comparison in progress is discarded with no partial pulse.
  - N_features=1: a comparison is one ACC cycle followed by RESULT.

## Timing
- Reset values: `svmready`=0, `w_class`=0, `busy`=0.
- `busy` rises on the edge after `start`.
- One comparison takes N_features+1 cycles: N_features ACC cycles, then RESULT.
- The first `svmready` pulse occurs N_features+1 cycles after the `start` edge.
- Pulses are spaced exactly N_features+1 cycles apart.
- The picker's `ready` is registered and rises the cycle after the final RESULT. That cycle is ACC idx=0, so the engine is back in IDLE 1 cycle later.
- A 7-class run (6 comparisons) takes 6·(N_features+1)+1 cycles from `start` to IDLE.
- `w_class` is valid in the same cycle as `svmready`.

## Structure
- Package `svm_engine_pkg` holds:
  - the state enum (IDLE/ACC/RESULT);
  - a `clog2`-based ACC_W function;
  - slice helpers for the weight and feature indices.
- One sub-module, `svm_mac_step`, is natural. It is combinational and computes the sign-extended w[idx]·x[idx] plus its addend. The top level handles the FSM, the idx counter, feature latching and output registers.

## Test plan
All scenarios use N_features=2, weightWidth=4, inputWidth=4, biasWidth=8.
- x=(3,5), w=(2,−1), bia=0, start → one `svmready` pulse 3 cycles after start with `w_class`=0 (sum=1).
- Same inputs with bia=−2 → `w_class`=1 (sum=−1); with bia=−1 → `w_class`=0 (sum=0, non-negative).
- Full system with the picker, 7 classes, features chosen so class 4 wins → picker `winner`=4 after 6 pulses. The engine reaches IDLE at cycle 19 after start.
- `start` pulsed mid-run with different features → ignored; results match the original features and `busy` stays high.
- `rst_n` low for 1 cycle during ACC idx=1 → next cycle `svmready`=0, `busy`=0, `w_class`=0. A fresh `start` then produces correct timing.
- Extremes: x=(15,15), w=(−8,−8), bia=−128 → sum=−368, no overflow, `w_class`=1.
